lock_timer_sched: RTL and testbench
===================================

# lock_timer_sched

Shared timer scheduler for the airlock interlock. One down-counter is time-multiplexed among the three timed phases: fill, drain and the 5 s pre-entry wait. The interlock FSM raises level requests (`filling`, `draining`, `waiting`). This block arbitrates among them, runs the granted duration and returns the matching `*Finished` level through a 4-phase handshake. It sits between the interlock FSM and nothing else; it owns no pumps or doors.

## Interface
- `FILL_CYCLES`, default 350_000_000: fill duration in clk cycles (7 s at 50 MHz), ≥1.
- `DRAIN_CYCLES`, default 400_000_000: drain duration (8 s), ≥1.
- `WAIT_CYCLES`, default 250_000_000: wait duration (5 s), ≥1.
- `CNT_W`, default 29: counter width; must hold max(*_CYCLES)−1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fillReq`  in  1  level; high while the interlock is in timerFill.
- `drainReq`  in  1  level; high while in timerDrain.
- `waitReq`  in  1  level; high while in waiting5.
- `hold`  in  1  freezes the countdown; only present with `LOCK_TIMER_PAUSE_EN`.
- `fillFinished`  out  1  level done for fill.
- `drainFinished`  out  1  level done for drain.
- `waitFinished`  out  1  level done for wait.
- `busy`  out  1  high in RUN or DONE.
- `grant`  out  2  00 none, 01 fill, 10 drain, 11 wait.
- `remaining`  out  CNT_W  cycles left in the current run.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:** if any request is high, grant by fixed priority drain > fill > wait.
  - `grant` ← code; `remaining` ← DUR−1; go to RUN.
  - No request: stay; `grant`=00.
- **RUN:**
  - Granted request low: abort to IDLE, `grant`←00, no done asserted.
  - `remaining`==0: go to DONE; assert the granted `*Finished`.
  - Otherwise `remaining` decrements by 1.
  - Other requests are ignored; no preemption, including by a later drain.
- **DONE:**
  - Granted `*Finished` stays high while the granted request is high.
  - When the request is seen low: deassert done, `grant`←00, go to IDLE. IDLE arbitrates again the following cycle.
- At most one `*Finished` is ever high.
- Requests other than the granted one are never acknowledged.
- The counter is unsigned and never wraps: it does not decrement below 0.
- Reset, at any time including mid-RUN: state IDLE, all outputs 0, `remaining`=0.

## Timing
- Request high at edge E0, state IDLE → RUN at E0, `grant` valid after E0.
- `*Finished` rises after edge E0+DUR. Grant-to-done latency is exactly DUR cycles, plus frozen cycles when the pause feature is built.
- Done falls on the first edge at which the granted request is sampled low.
- With the interlock, which drops its request on the edge that samples done, done is high for exactly 1 cycle. The request is 0 the cycle after that, so no retrigger occurs.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `LOCK_TIMER_PAUSE_EN` defined:
  - `hold` port exists.
  - In RUN with `hold`=1, `remaining` is frozen and no transition to DONE occurs.
  - Abort on request drop still takes effect.
- Undefined: `hold` port is absent; the countdown is unconditional.

## Structure
- `lock_timer_pkg`:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - grant codes GNT_NONE, GNT_FILL, GNT_DRAIN, GNT_WAIT.
- Sub-module `lock_down_counter` (width param; load, enable, value, zero flag). The scheduler FSM and arbiter live in the top.

## Test plan
Benches use FILL=4, DRAIN=6, WAIT=3, CNT_W=4.
- **Fill:** fillReq high at E0; interlock model drops it one cycle after done → `grant`=01; `fillFinished` high in the cycle after E0+4 for exactly 1 cycle; back to IDLE, `grant`=00.
- **Simultaneous:** drainReq and fillReq both high at E0 → drain granted; `drainFinished` after E0+6. Fill is then granted in the cycle after drainReq is seen low; `fillFinished` comes 4 cycles later.
- **No preemption:** wait running; drainReq rises 1 cycle in → `waitFinished` completes at 3 cycles, then drain is served.
- **Abort:** fillReq dropped when `remaining`=1 → IDLE next edge; no `fillFinished` pulse; `busy`=0.
- **Reset mid-RUN:** reset during drain with `remaining`=3 → next edge: all outputs 0; a new request restarts at the full DRAIN.
- **Pause (macro on):** `hold` high for 5 cycles during wait → `waitFinished` arrives at 3+5=8 cycles.

Source files
------------

// File: rtl/lock_timer_pkg.sv
// rtl/lock_timer_pkg.sv - state encoding, grant codes and helpers for the airlock timer scheduler
package lock_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'b00,
    GNT_FILL  = 2'b01,
    GNT_DRAIN = 2'b10,
    GNT_WAIT  = 2'b11
  } grant_t;

  // Fixed priority: drain beats fill beats wait.
  function automatic grant_t arbitrate(input logic fill_req, input logic drain_req,
                                       input logic wait_req);
    if (drain_req)     return GNT_DRAIN;
    else if (fill_req) return GNT_FILL;
    else if (wait_req) return GNT_WAIT;
    else               return GNT_NONE;
  endfunction

  // Level of the request that currently owns the timer.
  function automatic logic granted_req(input grant_t g, input logic fill_req,
                                       input logic drain_req, input logic wait_req);
    case (g)
      GNT_FILL:  return fill_req;
      GNT_DRAIN: return drain_req;
      GNT_WAIT:  return wait_req;
      default:   return 1'b0;
    endcase
  endfunction

  // Done vector ordered {wait, drain, fill}; one-hot by construction.
  function automatic logic [2:0] done_onehot(input grant_t g);
    case (g)
      GNT_FILL:  return 3'b001;
      GNT_DRAIN: return 3'b010;
      GNT_WAIT:  return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lock_down_counter.sv
// rtl/lock_down_counter.sv - loadable down-counter that saturates at zero
module lock_down_counter #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] value,
  output logic         zero
);

  // Load wins over count; the count stops at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (enable && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/lock_timer_sched.sv
// rtl/lock_timer_sched.sv - shared fill/drain/wait timer scheduler; optional hold via LOCK_TIMER_PAUSE_EN
module lock_timer_sched
  import lock_timer_pkg::*;
#(
  parameter int FILL_CYCLES  = 350_000_000,
  parameter int DRAIN_CYCLES = 400_000_000,
  parameter int WAIT_CYCLES  = 250_000_000,
  parameter int CNT_W        = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fillReq,
  input  logic             drainReq,
  input  logic             waitReq,
`ifdef LOCK_TIMER_PAUSE_EN
  input  logic             hold,
`endif
  output logic             fillFinished,
  output logic             drainFinished,
  output logic             waitFinished,
  output logic             busy,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  grant_t           grant_q, grant_d;
  grant_t           grant_new;
  logic [2:0]       done_q, done_d;
  logic             req_owned;
  logic             frozen;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_value, cnt_value;

`ifdef LOCK_TIMER_PAUSE_EN
  assign frozen = hold;
`else
  assign frozen = 1'b0;
`endif

  lock_down_counter #(.W(CNT_W)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (cnt_en),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  // State, grant and done flags are registered so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
      done_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  // Arbitrate in IDLE, count in RUN, hold done until the owning request drops.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    done_d         = done_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_en         = 1'b0;
    grant_new      = arbitrate(fillReq, drainReq, waitReq);
    req_owned      = granted_req(grant_q, fillReq, drainReq, waitReq);
    case (state_q)
      ST_IDLE: begin
        grant_d = GNT_NONE;
        done_d  = 3'b000;
        if (grant_new != GNT_NONE) begin
          grant_d  = grant_new;
          state_d  = ST_RUN;
          cnt_load = 1'b1;
          case (grant_new)
            GNT_FILL:  cnt_load_value = FILL_LOAD;
            GNT_DRAIN: cnt_load_value = DRAIN_LOAD;
            default:   cnt_load_value = WAIT_LOAD;
          endcase
        end
      end
      ST_RUN: begin
        if (!req_owned) begin
          // Abort: the interlock left the phase before the timer expired.
          state_d  = ST_IDLE;
          grant_d  = GNT_NONE;
          cnt_load = 1'b1;
        end else if (!frozen) begin
          if (cnt_zero) begin
            state_d = ST_DONE;
            done_d  = done_onehot(grant_q);
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!req_owned) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
          done_d  = 3'b000;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
        done_d  = 3'b000;
      end
    endcase
  end

  assign fillFinished  = done_q[0];
  assign drainFinished = done_q[1];
  assign waitFinished  = done_q[2];
  assign busy          = (state_q != ST_IDLE);
  assign grant         = grant_q;
  assign remaining     = cnt_value;

endmodule

// File: tb/tb_lock_timer_sched.sv
// tb/tb_lock_timer_sched.sv - directed self-checking bench for lock_timer_sched
module tb_lock_timer_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fillReq = 1'b0;
  logic       drainReq = 1'b0;
  logic       waitReq = 1'b0;
`ifdef LOCK_TIMER_PAUSE_EN
  logic       hold = 1'b0;
`endif
  logic       fillFinished, drainFinished, waitFinished, busy;
  logic [1:0] grant;
  logic [3:0] remaining;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  lock_timer_sched #(
    .FILL_CYCLES  (4),
    .DRAIN_CYCLES (6),
    .WAIT_CYCLES  (3),
    .CNT_W        (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fillReq       (fillReq),
    .drainReq      (drainReq),
    .waitReq       (waitReq),
`ifdef LOCK_TIMER_PAUSE_EN
    .hold          (hold),
`endif
    .fillFinished  (fillFinished),
    .drainFinished (drainFinished),
    .waitFinished  (waitFinished),
    .busy          (busy),
    .grant         (grant),
    .remaining     (remaining)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // fin is {wait, drain, fill}
  task automatic expect_out(input string tag, input logic [1:0] g, input logic [3:0] r,
                            input logic b, input logic [2:0] fin);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".remaining"}, 32'(remaining), 32'(r));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".finished"}, 32'({waitFinished, drainFinished, fillFinished}), 32'(fin));
  endtask

  initial begin
    // reset
    tick();
    tick();
    expect_out("reset", 2'd0, 4'd0, 1'b0, 3'b000);
    reset = 1'b0;

    // fill alone: done one cycle, dropped by the interlock on the edge that sees it
    fillReq = 1'b1;
    tick(); expect_out("fill_grant", 2'd1, 4'd3, 1'b1, 3'b000);
    tick(); tick(); tick();
    expect_out("fill_cnt0", 2'd1, 4'd0, 1'b1, 3'b000);
    tick(); expect_out("fill_done", 2'd1, 4'd0, 1'b1, 3'b001);
    fillReq = 1'b0;
    tick(); expect_out("fill_release", 2'd0, 4'd0, 1'b0, 3'b000);
    tick(); expect_out("fill_no_retrig", 2'd0, 4'd0, 1'b0, 3'b000);

    // simultaneous drain and fill: drain first, then fill
    fillReq = 1'b1;
    drainReq = 1'b1;
    tick(); expect_out("sim_grant", 2'd2, 4'd5, 1'b1, 3'b000);
    repeat (5) tick();
    expect_out("sim_cnt0", 2'd2, 4'd0, 1'b1, 3'b000);
    tick(); expect_out("sim_drain_done", 2'd2, 4'd0, 1'b1, 3'b010);
    drainReq = 1'b0;
    tick(); expect_out("sim_drain_release", 2'd0, 4'd0, 1'b0, 3'b000);
    tick(); expect_out("sim_fill_grant", 2'd1, 4'd3, 1'b1, 3'b000);
    repeat (3) tick();
    expect_out("sim_fill_cnt0", 2'd1, 4'd0, 1'b1, 3'b000);
    tick(); expect_out("sim_fill_done", 2'd1, 4'd0, 1'b1, 3'b001);
    fillReq = 1'b0;
    tick(); expect_out("sim_fill_release", 2'd0, 4'd0, 1'b0, 3'b000);

    // no preemption: drain arrives one cycle into wait
    waitReq = 1'b1;
    tick(); expect_out("np_grant", 2'd3, 4'd2, 1'b1, 3'b000);
    drainReq = 1'b1;
    tick(); expect_out("np_run1", 2'd3, 4'd1, 1'b1, 3'b000);
    tick(); expect_out("np_run2", 2'd3, 4'd0, 1'b1, 3'b000);
    tick(); expect_out("np_wait_done", 2'd3, 4'd0, 1'b1, 3'b100);
    waitReq = 1'b0;
    tick(); expect_out("np_release", 2'd0, 4'd0, 1'b0, 3'b000);
    tick(); expect_out("np_drain_grant", 2'd2, 4'd5, 1'b1, 3'b000);

    // reset mid-run with remaining == 3, then full restart
    tick(); tick();
    expect_out("rst_pre", 2'd2, 4'd3, 1'b1, 3'b000);
    reset = 1'b1;
    tick(); expect_out("rst_mid_run", 2'd0, 4'd0, 1'b0, 3'b000);
    reset = 1'b0;
    tick(); expect_out("rst_restart", 2'd2, 4'd5, 1'b1, 3'b000);
    drainReq = 1'b0;
    tick();
    chk("rst_abort.grant", 32'(grant), 32'd0);
    chk("rst_abort.busy", 32'(busy), 32'd0);
    chk("rst_abort.drainFinished", 32'(drainFinished), 32'd0);

    // abort fill at remaining == 1
    fillReq = 1'b1;
    tick(); expect_out("ab_grant", 2'd1, 4'd3, 1'b1, 3'b000);
    tick(); tick();
    expect_out("ab_rem1", 2'd1, 4'd1, 1'b1, 3'b000);
    fillReq = 1'b0;
    tick();
    chk("ab_idle.grant", 32'(grant), 32'd0);
    chk("ab_idle.busy", 32'(busy), 32'd0);
    chk("ab_idle.fillFinished", 32'(fillFinished), 32'd0);
    tick();
    chk("ab_later.fillFinished", 32'(fillFinished), 32'd0);
    chk("ab_later.busy", 32'(busy), 32'd0);

`ifdef LOCK_TIMER_PAUSE_EN
    // hold for 5 cycles during wait: done at 3 + 5 edges after grant
    waitReq = 1'b1;
    tick(); expect_out("pz_grant", 2'd3, 4'd2, 1'b1, 3'b000);
    hold = 1'b1;
    repeat (5) tick();
    expect_out("pz_frozen", 2'd3, 4'd2, 1'b1, 3'b000);
    hold = 1'b0;
    tick(); expect_out("pz_run1", 2'd3, 4'd1, 1'b1, 3'b000);
    tick(); expect_out("pz_run2", 2'd3, 4'd0, 1'b1, 3'b000);
    tick(); expect_out("pz_done", 2'd3, 4'd0, 1'b1, 3'b100);
    waitReq = 1'b0;
    tick(); expect_out("pz_release", 2'd0, 4'd0, 1'b0, 3'b000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
